scm_1row_access_ctrl: RTL and testbench

// Access controller for the one-row, latch-based SCM (one 64b write row, N_READ x 32b read ports).
// - Write side: accepts 32b half-row writes and merges them into a 64b shadow copy of the row.

---
 rtl/scm_1row_access_ctrl_if.sv | 37 +++
 rtl/scm_1row_access_ctrl.sv | 136 +++++++++++++
 tb/tb_scm_1row_access_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/scm_1row_access_ctrl_if.sv
// Bus bundle between the one-row SCM access controller, its write/read clients and the SCM macro.
// The master side is the client plus SCM model, the slave side is the controller.
interface scm_1row_access_ctrl_if #(
  parameter int NUM_REQ     = 4,
  parameter int N_READ      = 2,
  parameter int RDATA_WIDTH = 32,
  parameter int WDATA_WIDTH = 64,
  parameter int RADDR_WIDTH = $clog2(WDATA_WIDTH / RDATA_WIDTH)
);
  logic                            wr_valid;
  logic                            wr_ready;
  logic [RADDR_WIDTH-1:0]          wr_addr;
  logic [RDATA_WIDTH-1:0]          wr_data;
  logic [NUM_REQ-1:0]              rd_req_valid;
  logic [NUM_REQ-1:0]              rd_req_ready;
  logic [NUM_REQ*RADDR_WIDTH-1:0]  rd_req_addr;
  logic [NUM_REQ-1:0]              rd_rsp_valid;
  logic [NUM_REQ*RDATA_WIDTH-1:0]  rd_rsp_data;
  logic                            init_done;
  logic [N_READ-1:0]               scm_read_enable;
  logic [N_READ*RADDR_WIDTH-1:0]   scm_read_addr;
  logic [N_READ*RDATA_WIDTH-1:0]   scm_read_data;
  logic                            scm_write_enable;
  logic [WDATA_WIDTH-1:0]          scm_write_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req_valid, rd_req_addr, scm_read_data,
    input  wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data, init_done,
           scm_read_enable, scm_read_addr, scm_write_enable, scm_write_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req_valid, rd_req_addr, scm_read_data,
    output wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data, init_done,
           scm_read_enable, scm_read_addr, scm_write_enable, scm_write_data
  );
endinterface

// File: rtl/scm_1row_access_ctrl.sv
// Access controller for a one-row latch SCM: merges half-row writes into a shadow row,
// zero-initialises the row after reset and round-robin shares the read ports.
//   state   | meaning
//   ST_INIT | one-cycle zero write into the unreset latches; reads and writes held off
//   ST_RUN  | normal operation until the next reset
module scm_1row_access_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int N_READ      = 2,
  parameter int RDATA_WIDTH = 32,
  parameter int WDATA_WIDTH = 64,
  parameter int RADDR_WIDTH = $clog2(WDATA_WIDTH / RDATA_WIDTH)
) (
  input logic                   clk,
  input logic                   rst,
  scm_1row_access_ctrl_if.slave bus
);
  localparam int NUM_HALF = WDATA_WIDTH / RDATA_WIDTH;
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PORT_W   = (N_READ > 1) ? $clog2(N_READ) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t state, state_next;

  logic [RDATA_WIDTH-1:0] shadow [NUM_HALF];
  logic                   wr_pend;
  logic [PTR_W-1:0]       ptr;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [PORT_W-1:0]      rsp_port [NUM_REQ];

  logic                   write_en;
  logic                   blocked;
  logic                   accept;
  logic [NUM_REQ-1:0]     grant;
  logic [PORT_W-1:0]      port_of [NUM_REQ];
  logic [PTR_W-1:0]       last_idx;
  int                     cnt;
  int                     idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // The INIT write is masked while rst is high so every output reads 0 during reset.
  always_comb begin
    write_en      = 1'b0;
    bus.init_done = 1'b0;
    bus.wr_ready  = 1'b0;
    case (state)
      ST_INIT: write_en = ~rst;
      ST_RUN: begin
        write_en      = wr_pend;
        bus.init_done = 1'b1;
        bus.wr_ready  = 1'b1;
      end
      default: ;
    endcase
  end

  assign blocked              = write_en | (state == ST_INIT);
  assign accept               = bus.wr_valid & bus.wr_ready;
  assign bus.scm_write_enable = write_en;

  always_comb begin
    bus.scm_write_data = '0;
    if (write_en) begin
      for (int h = 0; h < NUM_HALF; h++)
        bus.scm_write_data[h*RDATA_WIDTH +: RDATA_WIDTH] = shadow[h];
    end
  end

  // Scan from the pointer with wrap; the k-th grant goes to read port k.
  always_comb begin
    grant               = '0;
    bus.scm_read_enable = '0;
    bus.scm_read_addr   = '0;
    last_idx            = '0;
    cnt                 = 0;
    idx                 = 0;
    for (int r = 0; r < NUM_REQ; r++) port_of[r] = '0;
    if (!blocked) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = int'(ptr) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (bus.rd_req_valid[idx] && (cnt < N_READ)) begin
          grant[idx]                  = 1'b1;
          port_of[idx]                = PORT_W'(cnt);
          bus.scm_read_enable[cnt]    = 1'b1;
          bus.scm_read_addr[cnt*RADDR_WIDTH +: RADDR_WIDTH] =
            bus.rd_req_addr[idx*RADDR_WIDTH +: RADDR_WIDTH];
          last_idx                    = PTR_W'(idx);
          cnt                         = cnt + 1;
        end
      end
    end
  end

  assign bus.rd_req_ready = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < NUM_HALF; h++) shadow[h] <= '0;
      wr_pend   <= 1'b0;
      ptr       <= '0;
      rsp_valid <= '0;
      for (int r = 0; r < NUM_REQ; r++) rsp_port[r] <= '0;
    end else begin
      wr_pend <= accept;
      if (accept) shadow[bus.wr_addr] <= bus.wr_data;
      if (|grant) ptr <= (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
      rsp_valid <= grant;
      for (int r = 0; r < NUM_REQ; r++)
        if (grant[r]) rsp_port[r] <= port_of[r];
    end
  end

  assign bus.rd_rsp_valid = rsp_valid;

  always_comb begin
    bus.rd_rsp_data = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (rsp_valid[r])
        bus.rd_rsp_data[r*RDATA_WIDTH +: RDATA_WIDTH] =
          bus.scm_read_data[int'(rsp_port[r])*RDATA_WIDTH +: RDATA_WIDTH];
    end
  end
endmodule

// File: tb/tb_scm_1row_access_ctrl.sv
// Bench for scm_1row_access_ctrl: SCM macro model, response scoreboard and directed
// grant/write checks, plus a single-read-port instance for the arbitration order.
module tb_scm_1row_access_ctrl;
  localparam int NUM_REQ = 4;
  localparam int N_READ  = 2;
  localparam int RW      = 32;
  localparam int WW      = 64;
  localparam int AW      = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  scm_1row_access_ctrl_if #(.NUM_REQ(NUM_REQ), .N_READ(N_READ), .RDATA_WIDTH(RW),
                            .WDATA_WIDTH(WW), .RADDR_WIDTH(AW)) bus ();
  scm_1row_access_ctrl_if #(.NUM_REQ(NUM_REQ), .N_READ(1), .RDATA_WIDTH(RW),
                            .WDATA_WIDTH(WW), .RADDR_WIDTH(AW)) bus1 ();

  scm_1row_access_ctrl #(.NUM_REQ(NUM_REQ), .N_READ(N_READ), .RDATA_WIDTH(RW),
                         .WDATA_WIDTH(WW), .RADDR_WIDTH(AW))
    u_dut (.clk(clk), .rst(rst), .bus(bus));

  scm_1row_access_ctrl #(.NUM_REQ(NUM_REQ), .N_READ(1), .RDATA_WIDTH(RW),
                         .WDATA_WIDTH(WW), .RADDR_WIDTH(AW))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // SCM macro: latch row without reset, read data presented the cycle after ReadEnable.
  logic [WW-1:0]        scm_row;
  logic [N_READ*RW-1:0] scm_rdata = '0;
  always @(posedge clk) begin
    for (int k = 0; k < N_READ; k++)
      if (bus.scm_read_enable[k])
        scm_rdata[k*RW +: RW] <= scm_row[bus.scm_read_addr[k*AW +: AW]*RW +: RW];
    if (bus.scm_write_enable) scm_row <= bus.scm_write_data;
  end
  assign bus.scm_read_data  = scm_rdata;
  assign bus1.scm_read_data = '0;

  typedef struct {
    int          req;
    logic [RW-1:0] data;
  } rsp_t;

  rsp_t               sb[$];
  rsp_t               e;
  logic [RW-1:0]      ref_half [2] = '{default: '0};
  logic [NUM_REQ-1:0] mon_mask;

  // A read granted in cycle G sees the row as it stood at the start of G.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      ref_half[0] = '0;
      ref_half[1] = '0;
      check("rsp_in_rst", 64'(bus.rd_rsp_valid), 64'd0);
    end else begin
      mon_mask = '0;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        mon_mask[e.req] = 1'b1;
        check($sformatf("rsp_data%0d", e.req), 64'(bus.rd_rsp_data[e.req*RW +: RW]), 64'(e.data));
      end
      check("rsp_valid", 64'(bus.rd_rsp_valid), 64'(mon_mask));
      for (int r = 0; r < NUM_REQ; r++) begin
        if (bus.rd_req_valid[r] && bus.rd_req_ready[r]) begin
          e.req  = r;
          e.data = ref_half[bus.rd_req_addr[r*AW +: AW]];
          sb.push_back(e);
        end
      end
      if (bus.wr_valid && bus.wr_ready) ref_half[bus.wr_addr] = bus.wr_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic [NUM_REQ-1:0] rr_exp [4] = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};

  initial begin
    bus.wr_valid      = 1'b0;
    bus.wr_addr       = '0;
    bus.wr_data       = '0;
    bus.rd_req_valid  = 4'hF;
    bus.rd_req_addr   = '0;
    bus1.wr_valid     = 1'b0;
    bus1.wr_addr      = '0;
    bus1.wr_data      = '0;
    bus1.rd_req_valid = '0;
    bus1.rd_req_addr  = '0;
    #1 rst = 1'b1;
    repeat (2) sample();
    check("rst_we",        64'(bus.scm_write_enable), 64'd0);
    check("rst_wdata",     bus.scm_write_data, 64'd0);
    check("rst_init_done", 64'(bus.init_done), 64'd0);
    check("rst_wr_ready",  64'(bus.wr_ready), 64'd0);
    check("rst_rd_ready",  64'(bus.rd_req_ready), 64'd0);

    step(); rst = 1'b0;
    sample();
    check("init_we",        64'(bus.scm_write_enable), 64'd1);
    check("init_wdata",     bus.scm_write_data, 64'd0);
    check("init_done_low",  64'(bus.init_done), 64'd0);
    check("init_wr_ready",  64'(bus.wr_ready), 64'd0);
    check("init_rd_ready",  64'(bus.rd_req_ready), 64'd0);
    check("init_rd_enable", 64'(bus.scm_read_enable), 64'd0);

    step(); bus.rd_req_valid = 4'b1100; bus.rd_req_addr = 4'b1000;
    sample();
    check("run_we",        64'(bus.scm_write_enable), 64'd0);
    check("run_init_done", 64'(bus.init_done), 64'd1);
    check("first_grant",   64'(bus.rd_req_ready), 64'b1100);

    step(); bus.rd_req_valid = '0;
    bus.wr_valid = 1'b1; bus.wr_addr = 1'b0; bus.wr_data = 32'hDEADBEEF;
    sample();
    check("wr_ready_a", 64'(bus.wr_ready), 64'd1);
    step(); bus.wr_addr = 1'b1; bus.wr_data = 32'h12345678;
    sample();
    check("wr_ready_b", 64'(bus.wr_ready), 64'd1);
    check("wr_we_a",    64'(bus.scm_write_enable), 64'd1);
    check("wr_data_a",  bus.scm_write_data, 64'h00000000DEADBEEF);
    step(); bus.wr_valid = 1'b0;
    sample();
    check("wr_we_b",    64'(bus.scm_write_enable), 64'd1);
    check("wr_data_b",  bus.scm_write_data, 64'h12345678DEADBEEF);
    step();
    sample();
    check("wr_we_idle", 64'(bus.scm_write_enable), 64'd0);

    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 0) begin
        bus.rd_req_valid = 4'hF;
        bus.rd_req_addr  = 4'b1010;
      end
      sample();
      check($sformatf("rr_grant%0d", c), 64'(bus.rd_req_ready), 64'(rr_exp[c]));
    end

    step(); bus.rd_req_valid = 4'b0100; bus.rd_req_addr = 4'b0100;
    bus.wr_valid = 1'b1; bus.wr_addr = 1'b1; bus.wr_data = 32'hA5A5A5A5;
    sample();
    check("ord_t_grant", 64'(bus.rd_req_ready), 64'b0100);
    check("ord_t_wr",    64'(bus.wr_ready), 64'd1);
    step(); bus.wr_valid = 1'b0;
    sample();
    check("ord_t1_ready",  64'(bus.rd_req_ready), 64'd0);
    check("ord_t1_enable", 64'(bus.scm_read_enable), 64'd0);
    step();
    sample();
    check("ord_t2_grant", 64'(bus.rd_req_ready), 64'b0100);

    step(); bus.rd_req_valid = 4'b1000; bus1.rd_req_valid = 4'b1000;
    sample();
    check("wrap_a",   64'(bus.rd_req_ready), 64'b1000);
    check("n1_wrap_a", 64'(bus1.rd_req_ready), 64'b1000);
    step(); bus.rd_req_valid = 4'b1001; bus1.rd_req_valid = 4'b1001;
    sample();
    check("wrap_b",   64'(bus.rd_req_ready), 64'b1001);
    check("n1_wrap_b", 64'(bus1.rd_req_ready), 64'b0001);
    step();
    sample();
    check("wrap_c",   64'(bus.rd_req_ready), 64'b1001);
    check("n1_wrap_c", 64'(bus1.rd_req_ready), 64'b1000);

    step(); bus.rd_req_valid = 4'b0001; bus.rd_req_addr = 4'b0001; bus1.rd_req_valid = '0;
    sample();
    check("pre_rst_grant", 64'(bus.rd_req_ready), 64'b0001);
    step(); rst = 1'b1; bus.rd_req_valid = '0;
    sample();
    check("mid_rst_rsp",  64'(bus.rd_rsp_valid), 64'd0);
    check("mid_rst_we",   64'(bus.scm_write_enable), 64'd0);
    check("mid_rst_done", 64'(bus.init_done), 64'd0);
    step(); rst = 1'b0; bus.rd_req_valid = 4'hF;
    sample();
    check("reinit_we",       64'(bus.scm_write_enable), 64'd1);
    check("reinit_wdata",    bus.scm_write_data, 64'd0);
    check("reinit_rd_ready", 64'(bus.rd_req_ready), 64'd0);
    step(); bus.rd_req_valid = 4'b0011; bus.rd_req_addr = 4'b0010;
    sample();
    check("post_rst_grant", 64'(bus.rd_req_ready), 64'b0011);
    check("post_rst_done",  64'(bus.init_done), 64'd1);
    step(); bus.rd_req_valid = '0;
    sample();
    step();
    sample();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
